// File: rtl/regfile_wport_arbiter.sv
// Write-port arbiter for the 2r1w zero-register register file: grants one of two
// val/rdy writeback sources per cycle, stages the winner, and flags read bypass hits.
// Build option: define REGFILE_WPORT_ARB_RR_EN for round-robin; default is fixed priority (requester 0 wins).
module regfile_wport_arbiter #(
    parameter int p_data_nbits = 32,
    parameter int p_addr_nbits = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_addr_nbits-1:0] req0_addr,
    input  logic [p_data_nbits-1:0] req0_data,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [p_addr_nbits-1:0] req1_addr,
    input  logic [p_data_nbits-1:0] req1_data,
    output logic                    wr_en,
    output logic [p_addr_nbits-1:0] wr_addr,
    output logic [p_data_nbits-1:0] wr_data,
    input  logic [p_addr_nbits-1:0] rd_addr0,
    input  logic [p_addr_nbits-1:0] rd_addr1,
    output logic                    byp_hit0,
    output logic                    byp_hit1
);

    logic                    prio_s;
    logic                    gnt0_s;
    logic                    gnt1_s;
    logic                    xfer0_s;
    logic                    xfer1_s;
    logic                    xfer_s;
    logic [p_addr_nbits-1:0] win_addr_s;
    logic [p_data_nbits-1:0] win_data_s;

    logic                    stg_val_r;
    logic [p_addr_nbits-1:0] stg_addr_r;
    logic [p_data_nbits-1:0] stg_data_r;

`ifdef REGFILE_WPORT_ARB_RR_EN
    logic prio_r;

    // Round-robin pointer: after a transfer, favour the requester that did not win
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_r <= 1'b0;
        end else if (xfer_s) begin
            prio_r <= xfer0_s;
        end else begin
            prio_r <= prio_r;
        end
    end

    assign prio_s = prio_r;
`else
    assign prio_s = 1'b0;
`endif

    // Grants: a requester's rdy only looks at the other requester's val, never its own
    always_comb begin
        gnt0_s = 1'b1;
        gnt1_s = 1'b1;
        if (req1_val && prio_s) begin
            gnt0_s = 1'b0;
        end else begin
            gnt0_s = 1'b1;
        end
        if (req0_val && !prio_s) begin
            gnt1_s = 1'b0;
        end else begin
            gnt1_s = 1'b1;
        end
    end

    assign xfer0_s = req0_val && gnt0_s;
    assign xfer1_s = req1_val && gnt1_s;
    assign xfer_s  = xfer0_s || xfer1_s;

    // Winner payload selection
    always_comb begin
        win_addr_s = req1_addr;
        win_data_s = req1_data;
        if (xfer0_s) begin
            win_addr_s = req0_addr;
            win_data_s = req0_data;
        end else begin
            win_addr_s = req1_addr;
            win_data_s = req1_data;
        end
    end

    // Staging register: drains every cycle; x0 writes are accepted but never enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_val_r  <= 1'b0;
            stg_addr_r <= {p_addr_nbits{1'b0}};
            stg_data_r <= {p_data_nbits{1'b0}};
        end else if (xfer_s) begin
            stg_val_r  <= (win_addr_s != {p_addr_nbits{1'b0}});
            stg_addr_r <= win_addr_s;
            stg_data_r <= win_data_s;
        end else begin
            stg_val_r  <= 1'b0;
            stg_addr_r <= stg_addr_r;
            stg_data_r <= stg_data_r;
        end
    end

    assign req0_rdy = gnt0_s;
    assign req1_rdy = gnt1_s;
    assign wr_en    = stg_val_r;
    assign wr_addr  = stg_addr_r;
    assign wr_data  = stg_data_r;
    assign byp_hit0 = stg_val_r && (rd_addr0 == stg_addr_r);
    assign byp_hit1 = stg_val_r && (rd_addr1 == stg_addr_r);

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Scoreboard bench for regfile_wport_arbiter: directed scenarios followed by random traffic,
// checked against an arbitration model built from last-winner bookkeeping and an expected-write queue.
module tb_regfile_wport_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_val = 1'b0, req1_val = 1'b0;
    logic          req0_rdy, req1_rdy;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr0 = '0, rd_addr1 = '0;
    logic          byp_hit0, byp_hit1;

    regfile_wport_arbiter #(.p_data_nbits(DW), .p_addr_nbits(AW)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_addr(req1_addr), .req1_data(req1_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .byp_hit0(byp_hit0), .byp_hit1(byp_hit1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        bit            en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            last_w = 1;
    bit            m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit            stim_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected winner from the arbitration rules: 0, 1, or -1 for none
    function automatic int model_grant(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef REGFILE_WPORT_ARB_RR_EN
            return 1 - last_w;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic drive(input bit v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input bit v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1, output int g);
        @(negedge clk);
        req0_val = v0; req0_addr = a0; req0_data = d0;
        req1_val = v1; req1_addr = a1; req1_data = d1;
        rd_addr0 = r0; rd_addr1 = r1;
        #1;
        g = model_grant(v0, v1);
        chk("xfer0", {63'd0, req0_val && req0_rdy}, {63'd0, g == 0});
        chk("xfer1", {63'd0, req1_val && req1_rdy}, {63'd0, g == 1});
        if (g >= 0) begin
            exp_t e;
            e.due  = cyc + 1;
            e.addr = (g == 0) ? a0 : a1;
            e.data = (g == 0) ? d0 : d1;
            e.en   = (e.addr != '0);
            sb_q.push_back(e);
            last_w = g;
        end
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        int g;
        drive(1'b0, '0, '0, 1'b0, '0, '0, r0, r1, g);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
        chk({tag, "_wr_addr"}, {59'd0, wr_addr}, 64'd0);
        chk({tag, "_wr_data"}, {32'd0, wr_data}, 64'd0);
        chk({tag, "_byp0"}, {63'd0, byp_hit0}, 64'd0);
        chk({tag, "_byp1"}, {63'd0, byp_hit1}, 64'd0);
    endtask

    // Monitor: compares the write port and bypass flags each cycle against the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                sb_q.delete();
                m_en = 1'b0; m_addr = '0; m_data = '0;
            end else begin
                m_en = 1'b0;
                if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    m_en = e.en; m_addr = e.addr; m_data = e.data;
                end
                chk("wr_en", {63'd0, wr_en}, {63'd0, m_en});
                chk("wr_addr", {59'd0, wr_addr}, {59'd0, m_addr});
                chk("wr_data", {32'd0, wr_data}, {32'd0, m_data});
                chk("byp_hit0", {63'd0, byp_hit0}, {63'd0, m_en && (rd_addr0 == m_addr)});
                chk("byp_hit1", {63'd0, byp_hit1}, {63'd0, m_en && (rd_addr1 == m_addr)});
            end
        end
    end

    // Stimulus: directed scenarios, mid-operation reset, then random traffic with val held until rdy
    initial begin
        int g;
        bit p0, p1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;

        repeat (3) @(negedge clk);
        chk_cleared("rst");
        reset = 1'b1;
        idle(5'd0, 5'd0);

        drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0, 5'd0, 5'd0, g);
        idle(5'd3, 5'd0);
        idle(5'd3, 5'd0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd5, 32'h0000_0505, 1'b1, 5'd6, 32'h0000_0606, 5'd5, 5'd6, g);
        end
        idle(5'd0, 5'd0);

        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, g);
        idle(5'd0, 5'd0);

        drive(1'b1, 5'd7, 32'h7777_0007, 1'b0, '0, '0, 5'd7, 5'd8, g);
        idle(5'd7, 5'd8);
        idle(5'd7, 5'd8);

        drive(1'b1, 5'd9, 32'h9999_0009, 1'b0, '0, '0, 5'd9, 5'd9, g);
        @(posedge clk);
        #3;
        chk("stg_before_rst", {63'd0, wr_en}, 64'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("async_rst_byp0", {63'd0, byp_hit0}, 64'd0);
        @(negedge clk);
        req0_val = 1'b0; req1_val = 1'b0;
        @(negedge clk);
        last_w = 1;
        reset = 1'b1;
        idle(5'd9, 5'd9);
        drive(1'b1, 5'd10, 32'hA0A0_000A, 1'b1, 5'd11, 32'hB0B0_000B, 5'd10, 5'd11, g);
        idle(5'd0, 5'd0);

        p0 = 1'b0; p1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] r0, r1;
            if (!p0 && ($urandom_range(2) != 0)) begin
                p0 = 1'b1;
                a0 = ($urandom_range(7) == 0) ? 5'd0 : AW'($urandom);
                d0 = $urandom;
            end
            if (!p1 && ($urandom_range(2) != 0)) begin
                p1 = 1'b1;
                a1 = ($urandom_range(7) == 0) ? 5'd0 : AW'($urandom);
                d1 = $urandom;
            end
            r0 = $urandom_range(1) ? a0 : AW'($urandom);
            r1 = $urandom_range(1) ? a1 : AW'($urandom);
            drive(p0, a0, d0, p1, a1, d1, r0, r1, g);
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
        end
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);
        stim_done = 1'b1;
    end

    // Finish once stimulus completes; the watchdog bounds the whole run
    initial begin
        fork
            begin
                wait (stim_done);
                @(posedge clk);
                #2;
                chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
            end
            begin
                #200000;
                n_bad++;
                $display("FAIL watchdog: got timeout expected stimulus completion");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
